// File: rtl/decode_stage_pkg.sv
// Shared types for the N-wide decode stage: opcodes, ALU op codes, skid states
// and the per-lane decode record.
package decode_stage_pkg;

  localparam int DEC_XLEN = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ALU_NOP = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_XOR = 3'b011,
    ALU_AND = 3'b100,
    ALU_SRA = 3'b101,
    ALU_OR  = 3'b110,
    ALU_SLL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  typedef struct packed {
    logic                lane_valid;
    logic                illegal;
    logic [4:0]          src0;
    logic [4:0]          src1;
    logic [4:0]          dst;
    logic [DEC_XLEN-1:0] imm;
    alu_op_e             alu_op;
    logic                alu_src;
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_read;
    logic                mem_write;
  } decode_struct;

endpackage

// File: rtl/decode_stage_inst_decoder.sv
// Single-lane combinational decoder for R/I/load/store formats; unknown
// encodings collapse to an illegal NOP, masked lanes to a plain NOP.
module inst_decoder
  import decode_stage_pkg::*;
#(
  parameter int XLEN = DEC_XLEN
) (
  input  logic [31:0]  inst,
  input  logic         lane_en,
  output decode_struct dec
);

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s_s;
  decode_struct    raw_s;
  logic            bad_s;

  assign opcode_s = inst[6:0];
  assign funct3_s = inst[14:12];
  assign funct7_s = inst[31:25];
  assign imm_i_s  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};

  // Format decode, then illegal/mask squashing
  always_comb begin
    raw_s = '0;
    bad_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        raw_s.src0       = inst[19:15];
        raw_s.src1       = inst[24:20];
        raw_s.dst        = inst[11:7];
        raw_s.reg_write  = 1'b1;
        raw_s.mem_to_reg = 1'b1;
        case ({funct7_s, funct3_s})
          {7'h00, 3'd0}: raw_s.alu_op = ALU_ADD;
          {7'h20, 3'd0}: raw_s.alu_op = ALU_SUB;
          {7'h00, 3'd4}: raw_s.alu_op = ALU_XOR;
          {7'h20, 3'd5}: raw_s.alu_op = ALU_SRA;
          {7'h00, 3'd6}: raw_s.alu_op = ALU_OR;
          {7'h00, 3'd7}: raw_s.alu_op = ALU_AND;
          {7'h00, 3'd1}: raw_s.alu_op = ALU_SLL;
          default:       bad_s        = 1'b1;
        endcase
      end
      OP_IMM: begin
        raw_s.src0       = inst[19:15];
        raw_s.dst        = inst[11:7];
        raw_s.imm        = imm_i_s;
        raw_s.alu_src    = 1'b1;
        raw_s.reg_write  = 1'b1;
        raw_s.mem_to_reg = 1'b1;
        case (funct3_s)
          3'd0:    raw_s.alu_op = ALU_ADD;
          3'd4:    raw_s.alu_op = ALU_XOR;
          3'd6:    raw_s.alu_op = ALU_OR;
          3'd7:    raw_s.alu_op = ALU_AND;
          default: bad_s        = 1'b1;
        endcase
      end
      OP_LOAD: begin
        raw_s.src0      = inst[19:15];
        raw_s.dst       = inst[11:7];
        raw_s.imm       = imm_i_s;
        raw_s.alu_op    = ALU_ADD;
        raw_s.alu_src   = 1'b1;
        raw_s.reg_write = 1'b1;
        raw_s.mem_read  = 1'b1;
      end
      OP_STORE: begin
        raw_s.src0      = inst[19:15];
        raw_s.src1      = inst[24:20];
        raw_s.imm       = imm_s_s;
        raw_s.alu_op    = ALU_ADD;
        raw_s.alu_src   = 1'b1;
        raw_s.mem_write = 1'b1;
      end
      default: bad_s = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded
    raw_s.reg_write = raw_s.reg_write & (|raw_s.dst);

    dec = '0;
    if (!lane_en) begin
      dec = '0;
    end else if (bad_s) begin
      dec.lane_valid = 1'b1;
      dec.illegal    = 1'b1;
    end else begin
      dec            = raw_s;
      dec.lane_valid = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// N-wide decode stage: per-lane decoders feeding a registered valid/ready
// output with a two-entry skid buffer. Optional trace: DECODE_TRACE_EN.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int ISSUE_WIDTH = 2,
  parameter int XLEN        = DEC_XLEN
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [31:0]            i_insts [0:ISSUE_WIDTH-1],
  input  logic [ISSUE_WIDTH-1:0] i_lane_mask,
  output logic                   o_valid,
  input  logic                   i_ready,
  output decode_struct           o_decode_data [0:ISSUE_WIDTH-1]
);

  decode_struct dec_s  [0:ISSUE_WIDTH-1];
  decode_struct main_r [0:ISSUE_WIDTH-1];
  decode_struct skid_r [0:ISSUE_WIDTH-1];

  skid_state_e state_r;
  skid_state_e next_s;
  logic        valid_r;
  logic        ready_r;
  logic        accept_s;
  logic        xfer_s;
  logic        load_main_s;
  logic        load_skid_s;
  logic        pop_skid_s;

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
    inst_decoder #(.XLEN(XLEN)) u_dec (
      .inst    (i_insts[g]),
      .lane_en (i_lane_mask[g]),
      .dec     (dec_s[g])
    );
  end

  assign accept_s = i_valid & ready_r;
  assign xfer_s   = valid_r & i_ready;

  // Next-state and buffer steering; flush overrides everything
  always_comb begin
    next_s      = state_r;
    load_main_s = 1'b0;
    load_skid_s = 1'b0;
    pop_skid_s  = 1'b0;
    if (i_flush) begin
      next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            next_s      = ST_ONE;
            load_main_s = 1'b1;
          end else begin
            next_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && xfer_s) begin
            next_s      = ST_ONE;
            load_main_s = 1'b1;
          end else if (accept_s) begin
            next_s      = ST_FULL;
            load_skid_s = 1'b1;
          end else if (xfer_s) begin
            next_s = ST_EMPTY;
          end else begin
            next_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (xfer_s) begin
            next_s     = ST_ONE;
            pop_skid_s = 1'b1;
          end else begin
            next_s = ST_FULL;
          end
        end
        default: next_s = ST_EMPTY;
      endcase
    end
  end

  // State plus registered handshake flags derived from the next state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= next_s;
      valid_r <= (next_s != ST_EMPTY);
      ready_r <= (next_s != ST_FULL);
    end
  end

  // Main/skid data registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        main_r[l] <= '0;
        skid_r[l] <= '0;
      end
    end else begin
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        if (load_main_s) begin
          main_r[l] <= dec_s[l];
        end else if (pop_skid_s) begin
          main_r[l] <= skid_r[l];
        end else begin
          main_r[l] <= main_r[l];
        end
        if (load_skid_s) begin
          skid_r[l] <= dec_s[l];
        end else begin
          skid_r[l] <= skid_r[l];
        end
      end
    end
  end

  assign o_valid       = valid_r;
  assign o_ready       = ready_r;
  assign o_decode_data = main_r;

`ifdef DECODE_TRACE_EN
  // Simulation-only trace of every accepted bundle
  always @(posedge i_clk) begin
    if (i_rst_n && !i_flush && accept_s) begin
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
        $display("decode lane %0d fmt=%s src0=%0d src1=%0d dst=%0d imm=%h", l,
                 (!dec_s[l].lane_valid) ? "off" :
                 dec_s[l].illegal ? "ill" :
                 (i_insts[l][6:0] == OP_R) ? "R" :
                 (i_insts[l][6:0] == OP_IMM) ? "I" :
                 (i_insts[l][6:0] == OP_LOAD) ? "L" : "S",
                 dec_s[l].src0, dec_s[l].src1, dec_s[l].dst, dec_s[l].imm);
      end
    end
  end
`else
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised N-wide RISC-V decode stage, the successor to the fixed dual-issue decoder. It sits between fetch and rename/issue. Each lane decodes R/I/load/store formats into a decode_struct with a fully sign-extended immediate. Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so backpressure never drops a bundle. A flush input kills all in-flight bundles.

Parameters:
ISSUE_WIDTH, 2, number of decode lanes per bundle (1..8)
XLEN, 32, immediate/data width; immediates sign-extend to XLEN

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
i_flush  in  1  kill all buffered bundles
i_valid  in  1  fetch bundle valid
o_ready  out  1  stage can accept a bundle this cycle
i_insts  in  word[0:ISSUE_WIDTH-1]  instruction per lane
i_lane_mask  in  ISSUE_WIDTH  per-lane valid within the bundle
o_valid  out  1  o_decode_data holds a valid bundle
i_ready  in  1  downstream accepts the bundle
o_decode_data  out  decode_struct[0:ISSUE_WIDTH-1]  decoded lanes

Behaviour:
- Reset: applied on rising i_clk when i_rst_n=0. Clears o_valid=0, o_ready=1, o_decode_data all-zero (NOP), state EMPTY. A reset mid-operation discards both buffer entries.
- Accept when i_valid&&o_ready. Transfer out when o_valid&&i_ready.
- Latency: an accepted bundle appears on o_decode_data with o_valid=1 on the next edge.
- States (count of held bundles):
  - EMPTY: accept -> ONE.
  - ONE: accept&&transfer -> ONE, new bundle in main register. Accept only -> FULL, new bundle in skid. Transfer only -> EMPTY.
  - FULL: transfer -> ONE, skid moves into main. Otherwise stay.
- o_ready is registered. It is 0 only in FULL, so never combinational from i_ready.
- Ordering is strict FIFO. Skid contents always go out after main contents.
- Flush: wins over accept and transfer in the same cycle. The incoming bundle is dropped. Next state EMPTY, o_valid=0, o_ready=1.
- Per-lane decode, by opcode [6:0]:
  - 0110011 R-type: src0=[19:15], src1=[24:20], dst=[11:7], imm=0, ALUSrc=0, RegWrite=1, MemtoReg=1.
  - 0010011 I-type: src1=0, imm=sext([31:20]), ALUSrc=1, RegWrite=1, MemtoReg=1.
  - 0000011 LW: as I-type with ALUOp=ADD, MemRead=1, MemtoReg=0.
  - 0100011 SW: dst=0, imm=sext({[31:25],[11:7]}), ALUOp=ADD, ALUSrc=1, MemWrite=1, RegWrite=0.
- ALUOp codes: NOP=000, ADD=001, SUB=010, XOR=011, AND=100, SRA=101, OR=110, SLL=111.
  - R-type {funct7,funct3}: 00/0 ADD, 20/0 SUB, 00/4 XOR, 20/5 SRA, 00/6 OR, 00/7 AND, 00/1 SLL.
  - I-type funct3: 0 ADDI, 4 XORI, 6 ORI, 7 ANDI.
- Unrecognised opcode or funct combination: lane becomes an all-zero NOP with illegal=1.
- A masked lane (i_lane_mask[i]=0) becomes an all-zero NOP with lane_valid=0 and illegal=0. Otherwise lane_valid=1.
- dst=x0 forces RegWrite=0.

Optional Feature:
DECODE_TRACE_EN
- Defined: every accepted bundle prints, per lane, the lane index, format, src0, src1, dst and immediate. This is simulation-only and has no effect on logic.
- Undefined: no $display statements are compiled.

Decomposition:
- Types package additions:
  - decode_struct gains lane_valid, illegal, and immediate widened to XLEN.
  - alu_op_e enum with the codes above.
  - Opcode localparams OP_R, OP_IMM, OP_LOAD, OP_STORE.
- One combinational sub-module, inst_decoder: single lane, word in, decode_struct out, instantiated ISSUE_WIDTH times.
- decode_stage holds only the skid/handshake logic.

Test Plan:
1. Reset with i_rst_n=0 for 2 cycles -> o_valid=0, o_ready=1, all lanes zero.
2. Lane0=0x002081B3 (add x3,x1,x2), lane1=0x402081B3 (sub), i_ready=1 -> next cycle src0=1, src1=2, dst=3, ALUOp 001 and 010, o_valid=1.
3. Lane0=0xFFF00293 (addi x5,x0,-1), lane1=0x0020A423 (sw x2,8(x1)) -> imm 0xFFFFFFFF, ALUSrc=1. Then imm=8, MemWrite=1, RegWrite=0, dst=0.
4. i_ready=0 while 3 bundles are offered -> o_ready drops after 2 accepted. Raising i_ready drains them in order with no loss or duplication.
5. i_flush=1 in FULL with i_valid=1 -> next cycle o_valid=0, o_ready=1, and no flushed or incoming bundle ever appears.
6. Lane0=0x0000007F with i_lane_mask=2'b01, lane1=0x0040A203 -> lane0 illegal=1 NOP. Lane1 lane_valid=0 NOP despite holding a valid lw.
